// File: rtl/discharge_pulse_timer.sv
// ---------------------------------------------------------------------------
// discharge_pulse_timer
//   Per-pulse discharge timebase for the EDM buck stage. Each pulse runs
//   through a discharge phase (TON, ton_l cycles) followed by a deionisation
//   phase (TOFF, toff_l+1 cycles). timer_buck_interleave is read directly by
//   the current-setpoint stage: 0 = not discharging, 1..ton_l = elapsed
//   discharge cycles.
//
//   Optional feature macro: BREAKDOWN_DETECT_EN
//     defined   -> each pulse first waits in WAIT_BD for the synchronised gap
//                  breakdown; after WAIT_MAX cycles without breakdown the
//                  pulse is abandoned (open_circuit strobe, straight to TOFF).
//     undefined -> pulses start directly in TON, breakdown is ignored and
//                  open_circuit is held at 0.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   enable                 level, 1 = machining allowed; 0 aborts to IDLE
//   Ton_timer, Toff_timer  discharge / off lengths, latched at pulse start
//   breakdown              asynchronous gap-breakdown comparator
//   clr_count              synchronous clear of pulse_count
//   timer_buck_interleave  elapsed discharge count, 0 outside TON
//   is_discharging         1 while in TON
//   pulse_done             1-cycle strobe on TON->TOFF
//   open_circuit           1-cycle strobe on breakdown-wait timeout
//   pulse_count            completed pulses, saturating
//   state                  IDLE=0, WAIT_BD=1, TON=2, TOFF=3
// ---------------------------------------------------------------------------
module discharge_pulse_timer #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] Ton_timer,
  input  logic [CNT_W-1:0] Toff_timer,
  input  logic             breakdown,
  input  logic             clr_count,
  output logic [CNT_W-1:0] timer_buck_interleave,
  output logic             is_discharging,
  output logic             pulse_done,
  output logic             open_circuit,
  output logic [CNT_W-1:0] pulse_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_BD = 2'd1,
    S_TON     = 2'd2,
    S_TOFF    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ALL1 = {CNT_W{1'b1}};

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] timer_r, timer_nxt_s;
  logic [CNT_W-1:0] ton_l_r, ton_l_nxt_s;
  logic [CNT_W-1:0] toff_l_r, toff_l_nxt_s;
  logic [CNT_W-1:0] toff_cnt_r, toff_cnt_nxt_s;
  logic [CNT_W-1:0] pulse_count_r;
  logic             pulse_done_r, pulse_done_nxt_s;
  logic             open_circuit_r, open_circuit_nxt_s;
  logic             is_discharging_r;
  logic             start_s;

`ifdef BREAKDOWN_DETECT_EN
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  // The wait times out in the WAIT_MAX-th cycle spent in WAIT_BD.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  logic              bd_meta_r, bd_sync_r;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;

  // Two-flop synchroniser for the asynchronous breakdown comparator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bd_meta_r <= 1'b0;
      bd_sync_r <= 1'b0;
    end else begin
      bd_meta_r <= breakdown;
      bd_sync_r <= bd_meta_r;
    end
  end

  // Breakdown wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end
`else
  // Breakdown input and wait limit have no function in this build.
  logic unused_breakdown_s;
  localparam int unused_wait_max = WAIT_MAX;
  assign unused_breakdown_s = breakdown;
`endif

  // Next-state, timer and strobe logic. enable=0 overrides everything.
  always_comb begin
    state_nxt_s        = state_r;
    timer_nxt_s        = timer_r;
    ton_l_nxt_s        = ton_l_r;
    toff_l_nxt_s       = toff_l_r;
    toff_cnt_nxt_s     = toff_cnt_r;
    pulse_done_nxt_s   = 1'b0;
    open_circuit_nxt_s = 1'b0;
    start_s            = 1'b0;
`ifdef BREAKDOWN_DETECT_EN
    wait_cnt_nxt_s     = wait_cnt_r;
`endif

    if (!enable) begin
      state_nxt_s    = S_IDLE;
      timer_nxt_s    = ZERO;
      toff_cnt_nxt_s = ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (Ton_timer != ZERO) begin
            start_s = 1'b1;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_WAIT_BD: begin
`ifdef BREAKDOWN_DETECT_EN
          if (bd_sync_r) begin
            state_nxt_s = S_TON;
            timer_nxt_s = ONE;
          end else if (wait_cnt_r >= WAIT_LAST) begin
            state_nxt_s        = S_TOFF;
            toff_cnt_nxt_s     = ZERO;
            open_circuit_nxt_s = 1'b1;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
          end
`else
          state_nxt_s = S_IDLE;
`endif
        end
        S_TON: begin
          // ">=" keeps the timer bounded even if ton_l were ever below it.
          if (timer_r >= ton_l_r) begin
            state_nxt_s      = S_TOFF;
            timer_nxt_s      = ZERO;
            toff_cnt_nxt_s   = ZERO;
            pulse_done_nxt_s = 1'b1;
          end else begin
            timer_nxt_s = timer_r + ONE;
          end
        end
        S_TOFF: begin
          // TOFF starts at toff_cnt=0 and ends at toff_l: toff_l+1 cycles.
          if (toff_cnt_r >= toff_l_r) begin
            toff_cnt_nxt_s = ZERO;
            if (Ton_timer != ZERO) begin
              start_s = 1'b1;
            end else begin
              state_nxt_s = S_IDLE;
            end
          end else begin
            toff_cnt_nxt_s = toff_cnt_r + ONE;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
          timer_nxt_s = ZERO;
        end
      endcase
    end

    // Pulse start: latch lengths so mid-pulse input changes wait a pulse.
    if (start_s) begin
      ton_l_nxt_s  = Ton_timer;
      toff_l_nxt_s = Toff_timer;
`ifdef BREAKDOWN_DETECT_EN
      state_nxt_s    = S_WAIT_BD;
      timer_nxt_s    = ZERO;
      wait_cnt_nxt_s = {WAIT_W{1'b0}};
`else
      state_nxt_s    = S_TON;
      timer_nxt_s    = ONE;
`endif
    end else begin
      ton_l_nxt_s  = ton_l_nxt_s;
      toff_l_nxt_s = toff_l_nxt_s;
    end
  end

  // State, timer, latched lengths and output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= S_IDLE;
      timer_r          <= ZERO;
      ton_l_r          <= ZERO;
      toff_l_r         <= ZERO;
      toff_cnt_r       <= ZERO;
      pulse_done_r     <= 1'b0;
      open_circuit_r   <= 1'b0;
      is_discharging_r <= 1'b0;
    end else begin
      state_r          <= state_nxt_s;
      timer_r          <= timer_nxt_s;
      ton_l_r          <= ton_l_nxt_s;
      toff_l_r         <= toff_l_nxt_s;
      toff_cnt_r       <= toff_cnt_nxt_s;
      pulse_done_r     <= pulse_done_nxt_s;
      open_circuit_r   <= open_circuit_nxt_s;
      is_discharging_r <= (state_nxt_s == S_TON);
    end
  end

  // Saturating pulse counter, updated together with the pulse_done strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_count_r <= ZERO;
    end else if (clr_count) begin
      pulse_count_r <= ZERO;
    end else if (pulse_done_nxt_s && (pulse_count_r != ALL1)) begin
      pulse_count_r <= pulse_count_r + ONE;
    end else begin
      pulse_count_r <= pulse_count_r;
    end
  end

  assign state                 = state_r;
  assign timer_buck_interleave = timer_r;
  assign is_discharging        = is_discharging_r;
  assign pulse_done            = pulse_done_r;
  assign open_circuit          = open_circuit_r;
  assign pulse_count           = pulse_count_r;

endmodule

// File: tb/tb_discharge_pulse_timer.sv
// Directed bench for discharge_pulse_timer. A 32-bit instance carries the
// main sequence; a 4-bit instance runs short pulses continuously so its
// counter reaches and holds saturation.
module tb_discharge_pulse_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] ton, toff;
  logic        breakdown;
  logic        clr_count;
  logic [31:0] timer;
  logic        is_dis, pd, oc;
  logic [31:0] count;
  logic [1:0]  st;

  logic        en2;
  logic [3:0]  timer2, count2;
  logic        is_dis2, pd2, oc2;
  logic [1:0]  st2;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  discharge_pulse_timer #(.CNT_W(32), .WAIT_MAX(50)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .Ton_timer(ton), .Toff_timer(toff), .breakdown(breakdown),
    .clr_count(clr_count),
    .timer_buck_interleave(timer), .is_discharging(is_dis),
    .pulse_done(pd), .open_circuit(oc), .pulse_count(count), .state(st)
  );

  discharge_pulse_timer #(.CNT_W(4), .WAIT_MAX(50)) dut_small (
    .clk(clk), .rst_n(rst_n), .enable(en2),
    .Ton_timer(4'd1), .Toff_timer(4'd0), .breakdown(1'b1),
    .clr_count(1'b0),
    .timer_buck_interleave(timer2), .is_discharging(is_dis2),
    .pulse_done(pd2), .open_circuit(oc2), .pulse_count(count2), .state(st2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one whole pulse starting in its first TON cycle.
  task automatic pulse_check(input string tag, input int ton_len, input int period);
    for (int c = 0; c < period; c++) begin
      if (c == ton_len) exp_count++;
      chk({tag, "_timer"}, timer, (c < ton_len) ? 32'(c + 1) : 32'd0);
      chk({tag, "_state"}, 32'(st), (c < ton_len) ? 32'd2 : 32'd3);
      chk({tag, "_pd"}, 32'(pd), (c == ton_len) ? 32'd1 : 32'd0);
      chk({tag, "_count"}, count, 32'(exp_count));
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; ton = 32'd10; toff = 32'd5;
    breakdown = 1'b0; clr_count = 1'b0; en2 = 1'b0;
    #12;
    chk("rst_timer", timer, 32'd0);
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_isdis", 32'(is_dis), 32'd0);
    chk("rst_pd", 32'(pd), 32'd0);
    chk("rst_oc", 32'(oc), 32'd0);
    chk("rst_count", count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    en2 = 1'b1;

`ifndef BREAKDOWN_DETECT_EN
    // T1: Ton=10, Toff=5 -> 16-cycle period; timer=1 one edge after enable.
    enable = 1'b1;
    step();
    pulse_check("t1p1", 10, 16);
    pulse_check("t1p2", 10, 16);
    pulse_check("t1p3", 10, 16);
    chk("t1_count3", count, 32'd3);
    // T2: Ton changed during TON only affects the following pulse.
    ton = 32'd20;
    pulse_check("t2p1", 10, 16);
    pulse_check("t2p2", 20, 26);
    // T3: enable drop at timer=4 aborts without a pulse.
    step(); step(); step();
    chk("t3_timer4", timer, 32'd4);
    enable = 1'b0;
    step();
    chk("t3_state", 32'(st), 32'd0);
    chk("t3_timer", timer, 32'd0);
    chk("t3_pd", 32'(pd), 32'd0);
    chk("t3_count", count, 32'd5);
    // Ton=0 keeps IDLE even with enable high.
    ton = 32'd0; enable = 1'b1;
    step(); step();
    chk("ton0_idle", 32'(st), 32'd0);
    // Ton=3, Toff=0: one TOFF cycle, then Ton=0 re-entry goes to IDLE.
    ton = 32'd3; toff = 32'd0;
    step();
    chk("lat_timer1", timer, 32'd1);
    step(); step();
    chk("short_timer3", timer, 32'd3);
    step();
    chk("short_state", 32'(st), 32'd3);
    chk("short_pd", 32'(pd), 32'd1);
    chk("short_count", count, 32'd6);
    ton = 32'd0;
    step();
    chk("reentry_idle", 32'(st), 32'd0);
    chk("reentry_pd", 32'(pd), 32'd0);
    // clr_count together with pulse_done gives 0.
    ton = 32'd2;
    step();
    chk("clr_timer1", timer, 32'd1);
    step();
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    chk("clr_pd", 32'(pd), 32'd1);
    chk("clr_count", count, 32'd0);
`else
    // T4: no breakdown -> open_circuit after 50 cycles in WAIT_BD.
    ton = 32'd4; toff = 32'd2; enable = 1'b1;
    step();
    chk("t4_state_wait", 32'(st), 32'd1);
    chk("t4_timer0", timer, 32'd0);
    for (int i = 0; i < 49; i++) begin
      step();
      chk("t4_wait", 32'(st), 32'd1);
      chk("t4_oc_low", 32'(oc), 32'd0);
    end
    step();
    chk("t4_state_toff", 32'(st), 32'd3);
    chk("t4_oc", 32'(oc), 32'd1);
    chk("t4_count", count, 32'd0);
    step();
    chk("t4_oc_strobe", 32'(oc), 32'd0);
    step();
    chk("t4_toff3", 32'(st), 32'd3);
    step();
    chk("t4_rewait", 32'(st), 32'd1);
    // T5: breakdown after 7 WAIT_BD cycles; timer=1 at the 3rd edge.
    for (int i = 0; i < 6; i++) step();
    breakdown = 1'b1;
    step();
    chk("t5_sync1", 32'(st), 32'd1);
    step();
    chk("t5_sync2", 32'(st), 32'd1);
    step();
    chk("t5_state", 32'(st), 32'd2);
    chk("t5_timer1", timer, 32'd1);
    step(); step(); step();
    chk("t5_timer4", timer, 32'd4);
    step();
    chk("t5_toff", 32'(st), 32'd3);
    chk("t5_pd", 32'(pd), 32'd1);
    chk("t5_count", count, 32'd1);
`endif

    // Small instance has completed far more than 15 pulses by now.
    chk("sat_count", 32'(count2), 32'd15);

    // Async reset mid-TON clears everything without a clock edge.
    for (int i = 0; i < 20 && !is_dis; i++) step();
    chk("pre_rst_ton", 32'(is_dis), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_timer", timer, 32'd0);
    chk("arst_state", 32'(st), 32'd0);
    chk("arst_isdis", 32'(is_dis), 32'd0);
    chk("arst_pd", 32'(pd), 32'd0);
    chk("arst_oc", 32'(oc), 32'd0);
    chk("arst_count", count, 32'd0);
    chk("arst_count2", 32'(count2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
